// File: rtl/vga_pkg.sv
// Shared timing definitions for the 800x600 @ 72 Hz video pipeline.
// The background and sprite stages import this package so that they agree
// on the active area and on the coordinate type.
package vga_pkg;

    // Signed pixel coordinate: non-negative inside the active area,
    // negative during blanking.
    typedef logic signed [10:0] coord_t;

    // Default 800x600 @ 72 Hz timing (50 MHz pixel clock).
    localparam int HACTIVE = 800;
    localparam int HFP     = 56;
    localparam int HSYNC   = 120;
    localparam int HBP     = 64;
    localparam int VACTIVE = 600;
    localparam int VFP     = 37;
    localparam int VSYNC   = 6;
    localparam int VBP     = 23;

    localparam int HBLANK  = HFP + HSYNC + HBP;   // 240
    localparam int HTOTAL  = HACTIVE + HBLANK;    // 1040
    localparam int VBLANK  = VFP + VSYNC + VBP;   // 66
    localparam int VTOTAL  = VACTIVE + VBLANK;    // 666

    // Position of a coordinate within one axis period. Blanking is laid out
    // as front porch, sync, back porch, immediately followed by the active area.
    typedef enum logic [1:0] {
        PH_FP     = 2'd0,
        PH_SYNC   = 2'd1,
        PH_BP     = 2'd2,
        PH_ACTIVE = 2'd3
    } phase_t;

    // Classify a coordinate for an axis with the given porch/sync widths.
    function automatic phase_t axis_phase(input coord_t c, input int fp,
                                          input int sync, input int bp);
        int     ci;
        int     first;
        phase_t ph;
        ci    = int'(c);
        first = -(fp + sync + bp);
        if (ci >= 0)
            ph = PH_ACTIVE;
        else if (ci < first + fp)
            ph = PH_FP;
        else if (ci < first + fp + sync)
            ph = PH_SYNC;
        else
            ph = PH_BP;
        return ph;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the video timing: a signed coordinate counting
// -(FP+SYNC+BP) .. ACTIVE-1 and wrapping, plus a registered sync level.
// The next-state coordinate and its phase are exported so the parent can
// register its own decodes with zero skew against the coordinate.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE   = vga_pkg::HACTIVE,
    parameter int FP       = vga_pkg::HFP,
    parameter int SYNC     = vga_pkg::HSYNC,
    parameter int BP       = vga_pkg::HBP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   step,
    output coord_t coord,
    output coord_t coord_nxt,
    output phase_t phase_nxt,
    output logic   sync,
    output logic   wrap
);

    localparam int     BLANK = FP + SYNC + BP;
    localparam coord_t FIRST = coord_t'(-BLANK);
    localparam coord_t LAST  = coord_t'(ACTIVE - 1);

    // This step takes the coordinate from the last active position back
    // to the start of blanking; the parent uses it to advance the next axis.
    assign wrap = step && (coord == LAST);

    // Next-state coordinate and its phase; holds when not stepping.
    always_comb begin
        coord_nxt = coord;
        if (step) begin
            if (wrap)
                coord_nxt = FIRST;
            else
                coord_nxt = coord + coord_t'(1);
        end
        phase_nxt = axis_phase(coord_nxt, FP, SYNC, BP);
    end

    // Coordinate and sync registers; sync is decoded from the next state
    // so it describes the same position as the coordinate it sits beside.
    always_ff @(posedge clk) begin
        if (rst) begin
            coord <= FIRST;
            sync  <= !SYNC_POL;
        end else if (step) begin
            coord <= coord_nxt;
            sync  <= (phase_nxt == PH_SYNC) ? SYNC_POL : !SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Video timing generator for 800x600 @ 72 Hz (50 MHz pixel clock).
// Produces signed pixel coordinates for the pixel stages plus sync, blank
// and line/frame markers for the DAC/HDMI output. Every output is registered
// and, by default, describes the same pixel as spotX/spotY in that cycle.
// Optional build macro VGA_SYNC_ALIGN_EN: delays hsync, vsync, blank and
// frame_start by one further pixel so they line up with the registered
// colour output of the background stage; spotX/spotY are not delayed.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HACTIVE = vga_pkg::HACTIVE,
    parameter int HFP     = vga_pkg::HFP,
    parameter int HSYNC   = vga_pkg::HSYNC,
    parameter int HBP     = vga_pkg::HBP,
    parameter int VACTIVE = vga_pkg::VACTIVE,
    parameter int VFP     = vga_pkg::VFP,
    parameter int VSYNC   = vga_pkg::VSYNC,
    parameter int VBP     = vga_pkg::VBP,
    parameter bit HS_POL  = 1'b1,
    parameter bit VS_POL  = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   ce,
    output coord_t spotX,
    output coord_t spotY,
    output logic   hsync,
    output logic   vsync,
    output logic   blank,
    output logic   line_start,
    output logic   frame_start
);

    localparam coord_t H_FIRST = coord_t'(-(HFP + HSYNC + HBP));

    coord_t h_nxt;
    coord_t v_nxt;
    phase_t h_ph_nxt;
    phase_t v_ph_nxt;
    logic   h_wrap;
    logic   v_wrap;
    logic   v_step;
    logic   hsync_r;
    logic   vsync_r;
    logic   blank_r;
    logic   line_start_r;
    logic   frame_start_r;

    // The vertical axis advances once per completed line.
    assign v_step = ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE   (HACTIVE),
        .FP       (HFP),
        .SYNC     (HSYNC),
        .BP       (HBP),
        .SYNC_POL (HS_POL)
    ) u_h (
        .clk       (clk),
        .rst       (rst),
        .step      (ce),
        .coord     (spotX),
        .coord_nxt (h_nxt),
        .phase_nxt (h_ph_nxt),
        .sync      (hsync_r),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE   (VACTIVE),
        .FP       (VFP),
        .SYNC     (VSYNC),
        .BP       (VBP),
        .SYNC_POL (VS_POL)
    ) u_v (
        .clk       (clk),
        .rst       (rst),
        .step      (v_step),
        .coord     (spotY),
        .coord_nxt (v_nxt),
        .phase_nxt (v_ph_nxt),
        .sync      (vsync_r),
        .wrap      (v_wrap)
    );

    // Blank and the line/frame markers, decoded from the next-state
    // coordinates; with ce low they hold, so a pulse is never re-issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_r       <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (ce) begin
            blank_r       <= (h_ph_nxt != PH_ACTIVE) || (v_ph_nxt != PH_ACTIVE);
            line_start_r  <= (h_nxt == H_FIRST);
            frame_start_r <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign line_start = line_start_r;

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_d;
    logic vsync_d;
    logic blank_d;
    logic frame_start_d;

    // Extra pixel of delay matching the background stage's colour register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_d       <= !HS_POL;
            vsync_d       <= !VS_POL;
            blank_d       <= 1'b1;
            frame_start_d <= 1'b0;
        end else if (ce) begin
            hsync_d       <= hsync_r;
            vsync_d       <= vsync_r;
            blank_d       <= blank_r;
            frame_start_d <= frame_start_r;
        end
    end

    assign hsync       = hsync_d;
    assign vsync       = vsync_d;
    assign blank       = blank_d;
    assign frame_start = frame_start_d;
`else
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign blank       = blank_r;
    assign frame_start = frame_start_r;
`endif

    // A frame can only end on the last pixel of a line.
    a_vwrap_on_hwrap : assert property (@(posedge clk) disable iff (rst) v_wrap |-> h_wrap);

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. A default-timing instance checks reset,
// horizontal sync edges, a full line and mid-line reset; a small-timing
// instance (12x6 pixel frame) makes full-frame and corner-wrap checks short.
module tb_vga_timing;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int ALIGN = 1;
`else
    localparam int ALIGN = 0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b = 1'b1;
    logic ce_b  = 1'b1;
    logic rst_s = 1'b1;
    logic ce_s  = 1'b1;

    logic signed [10:0] bx, by, sx, sy;
    logic b_hs, b_vs, b_blank, b_ls, b_fs;
    logic s_hs, s_vs, s_blank, s_ls, s_fs;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    vga_timing u_big (
        .clk         (clk),
        .rst         (rst_b),
        .ce          (ce_b),
        .spotX       (bx),
        .spotY       (by),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .blank       (b_blank),
        .line_start  (b_ls),
        .frame_start (b_fs)
    );

    // 6 active + 2/2/2 blanking pixels; 3 active + 1/1/1 blanking lines.
    vga_timing #(
        .HACTIVE (6), .HFP (2), .HSYNC (2), .HBP (2),
        .VACTIVE (3), .VFP (1), .VSYNC (1), .VBP (1)
    ) u_small (
        .clk         (clk),
        .rst         (rst_s),
        .ce          (ce_s),
        .spotX       (sx),
        .spotY       (sy),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .blank       (s_blank),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    // driver: advance n clock edges and land 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard comparison
    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_step[5];
        int hs_lvl[5];
        int cnt;
        int t;
        int vs_cnt;
        int act_cnt;
        int ls_cnt;
        int fs_cnt;

        // ---------------- reset, both instances ----------------
        tick(1);
        chk("big_rst_x", bx, -240);
        chk("big_rst_y", by, -66);
        chk("big_rst_blank", b_blank, 1);
        chk("big_rst_hsync", b_hs, 0);
        chk("big_rst_vsync", b_vs, 0);
        chk("big_rst_ls", b_ls, 0);
        chk("big_rst_fs", b_fs, 0);
        rst_b = 1'b0;
        ce_s  = 1'b0;

        // ---------------- hsync edges around the sync pulse ----------------
        hs_step = '{55, 1, 1, 118, 1};
        hs_lvl  = '{0, 1 - ALIGN, 1, 1, ALIGN};
        exp_q.push_back(-185);
        exp_q.push_back(-184);
        exp_q.push_back(-183);
        exp_q.push_back(-65);
        exp_q.push_back(-64);
        for (int k = 0; k < 5; k++) begin
            tick(hs_step[k]);
            chk($sformatf("hs_x[%0d]", k), bx, signed'(exp_q.pop_front()));
            chk($sformatf("hs_lvl[%0d]", k), b_hs, hs_lvl[k]);
        end
        chk("big_ls_after_rst", b_ls, 0);

        // ---------------- ce=0 holds everything ----------------
        ce_b = 1'b0;
        tick(5);
        chk("hold_x", bx, -64);
        chk("hold_hs", b_hs, ALIGN);
        ce_b = 1'b1;

        // ---------------- into the active columns of a blank line ----------------
        tick(63);
        chk("x_m1", bx, -1);
        chk("blank_x_m1", b_blank, 1);
        tick(1);
        chk("x_0", bx, 0);
        chk("blank_vblank_line", b_blank, 1);
        tick(799);
        chk("x_799", bx, 799);
        chk("ls_at_799", b_ls, 0);
        tick(1);
        chk("wrap_x", bx, -240);
        chk("wrap_y", by, -65);
        chk("wrap_ls", b_ls, 1);
        chk("vfp_vsync", b_vs, 0);

        // ---------------- one full line ----------------
        cnt = 0;
        for (int i = 0; i < 1040; i++) begin
            tick(1);
            if (b_ls) cnt++;
        end
        chk("line_ls_count", cnt, 1);
        chk("line_end_x", bx, -240);
        chk("line_end_y", by, -64);
        chk("line_end_ls", b_ls, 1);

        // ---------------- reset mid-line ----------------
        tick(540);
        chk("pre_rst_x", bx, 300);
        rst_b = 1'b1;
        tick(1);
        chk("mid_rst_x", bx, -240);
        chk("mid_rst_y", by, -66);
        chk("mid_rst_blank", b_blank, 1);
        chk("mid_rst_hs", b_hs, 0);
        rst_b = 1'b0;
        tick(1);
        chk("resume_x", bx, -239);
        chk("resume_y", by, -66);

        // ---------------- small instance: reset ----------------
        ce_b  = 1'b0;
        ce_s  = 1'b1;
        tick(1);
        chk("s_rst_x", sx, -6);
        chk("s_rst_y", sy, -3);
        chk("s_rst_blank", s_blank, 1);
        chk("s_rst_vs", s_vs, 0);
        rst_s = 1'b0;

        // first frame_start: 3 lines of 12 plus 6 pixels
        t = 0;
        while (s_fs !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        chk("s_first_fs_latency", t, 42 + ALIGN);

        // one full frame of 72 pixels between frame_start pulses
        vs_cnt  = 0;
        act_cnt = 0;
        ls_cnt  = 0;
        fs_cnt  = 0;
        for (int i = 0; i < 72; i++) begin
            tick(1);
            if (s_vs)     vs_cnt++;
            if (!s_blank) act_cnt++;
            if (s_ls)     ls_cnt++;
            if (s_fs)     fs_cnt++;
        end
        chk("s_frame_fs_count", fs_cnt, 1);
        chk("s_frame_fs_end", s_fs, 1);
        chk("s_frame_vsync_cycles", vs_cnt, 12);
        chk("s_frame_active_cycles", act_cnt, 18);
        chk("s_frame_ls_count", ls_cnt, 6);
        chk("s_frame_end_x", sx, ALIGN);
        chk("s_frame_end_y", sy, 0);

        // ---------------- simultaneous wrap with ce toggled ----------------
        tick(29 - ALIGN);
        chk("s_corner_x", sx, 5);
        chk("s_corner_y", sy, 2);
        chk("s_corner_blank", s_blank, 0);
        ce_s = 1'b0;
        tick(3);
        chk("s_hold_x", sx, 5);
        chk("s_hold_y", sy, 2);
        chk("s_hold_ls", s_ls, 0);
        ce_s = 1'b1;
        tick(1);
        chk("s_wrap_x", sx, -6);
        chk("s_wrap_y", sy, -3);
        chk("s_wrap_ls", s_ls, 1);
        chk("s_wrap_blank", s_blank, 1 - ALIGN);
        ce_s = 1'b0;
        tick(2);
        chk("s_ls_held", s_ls, 1);
        chk("s_x_held", sx, -6);
        ce_s = 1'b1;
        tick(1);
        chk("s_ls_not_reissued", s_ls, 0);
        chk("s_after_x", sx, -5);
        chk("s_after_blank", s_blank, 1);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
